irq_controller: RTL and testbench
=================================

Name: irq_controller

Overview:
- Memory-mapped interrupt aggregator sitting directly downstream of mtimer and the other peripherals.
- Collects up to NUM_SOURCES interrupt lines; mtimer.irq is wired to source 0 by convention.
- Latches and masks the sources, then presents one irq/irq_response handshake to the CPU core.
- Software identifies and acknowledges the winning source by reading a CLAIM register over the same request/response bus that mtimer uses.

Parameters:
- NUM_SOURCES, 16, number of interrupt inputs. Legal range 1..32. Register bits at or above NUM_SOURCES read 0 and ignore writes.

Ports:
- clock  input  1  single system clock.
- reset  input  1  reset, asynchronous and active-low: asserted when 0, released synchronously to clock by the system reset block.
- rw_address  input  32  byte address. Bits [4:2] select the register, bits [1:0] must be 0.
- read_data  output  32  registered read data.
- read_request  input  1  read strobe.
- read_response  output  1  read acknowledge.
- write_data  input  32  write data.
- write_strobe  input  4  byte enables.
- write_request  input  1  write strobe.
- write_response  output  1  write acknowledge.
- irq_sources  input  NUM_SOURCES  interrupt lines, synchronous to clock, active-high.
- irq  output  1  interrupt request to the CPU.
- irq_response  input  1  CPU acknowledge of irq, one-cycle pulse.

Behaviour:
- Reset value 0 for: ENABLE, PENDING, TRIGGER, the previous-sample register, read_data, read_response, write_response, irq. FSM resets to IDLE.
- Register map (word index = rw_address[4:2]):
  - 0 ENABLE: RW.
  - 1 PENDING: read; write-1-to-clear, edge sources only.
  - 2 TRIGGER: RW; bit=1 means rising-edge triggered, bit=0 means level.
  - 3 CLAIM: read-only, with side effect.
  - 4 STATUS: read-only; bit0 = any_active, bits[2:1] = FSM state.
  - Other indices read as 0 and ignore writes.
- Bus responses: read_response and write_response are registered copies of read_request and write_request, so latency is 1 cycle. They are always returned, including for misaligned or unmapped accesses.
- Reads: read_data updates only when read_request is high and the address is aligned; otherwise it holds its value.
- Writes: take effect on the clock edge of the request, and only if aligned and write_strobe=4'b1111. Partial writes are ignored but still acknowledged.
- Pending logic, per source i, every cycle:
  - Level (TRIGGER[i]=0): PENDING[i] <= irq_sources[i]. W1C has no effect.
  - Edge (TRIGGER[i]=1): set when irq_sources[i]=1 and prev[i]=0. Cleared by W1C or by a CLAIM of i. Set wins over a simultaneous clear.
  - prev[i] <= irq_sources[i] every cycle.
  - Changing TRIGGER does not clear PENDING.
- any_active = |(PENDING & ENABLE).
- CLAIM read:
  - Returns (lowest index i with PENDING[i]&ENABLE[i]) + 1, or 0 if none.
  - Same edge: clears PENDING[i] if TRIGGER[i]=1.
  - A claim with no active source has no side effect.
- IRQ FSM:
  - IDLE: irq=0. If any_active, go to ASSERT; irq=1 from the next cycle.
  - ASSERT: irq=1. On irq_response=1, go to WAIT_CLAIM with irq=0. If any_active drops first (source masked or cleared), return to IDLE with irq=0.
  - WAIT_CLAIM: irq=0. Go to IDLE on a CLAIM read, or when any_active=0.
  - irq_response outside ASSERT is ignored.
- Minimum gap between two irq assertions: 1 cycle in IDLE.
- Reset mid-operation: all state clears immediately (asynchronous). irq drops without waiting for the handshake.

Decomposition:
- Shared include/package holds:
  - register word indices (REG_ENABLE=0, REG_PENDING=1, REG_TRIGGER=2, REG_CLAIM=3, REG_STATUS=4);
  - FSM encodings (IDLE=2'd0, ASSERT=2'd1, WAIT_CLAIM=2'd2);
  - the claim-width constant ($clog2(NUM_SOURCES+1)).
- One sub-module: irq_gateway, instantiated once per source. It contains the prev sample, edge detect and pending set/clear arbitration. Inputs: trigger, w1c, claim_clear. Output: pending.
- The lowest-index priority encoder stays in the top level as a combinational loop.

Test Plan:
- Level source: ENABLE=0x1, TRIGGER=0, drive irq_sources[0]=1 -> PENDING reads 0x1. irq rises 2 cycles after the source (1 cycle pending + 1 cycle FSM). Pulse irq_response -> irq=0. CLAIM read returns 1. Drop the source -> PENDING=0.
- Edge source: TRIGGER=0x4, ENABLE=0x4, pulse irq_sources[2] for 1 cycle -> PENDING=0x4 persists after the pulse. CLAIM returns 3 and PENDING then reads 0. A second CLAIM returns 0.
- Priority: sources 5 and 3 pending and enabled -> CLAIM returns 4. The next CLAIM returns 6 (both edge-triggered).
- Simultaneous events: W1C of bit 1 on the same edge as a new rising edge on source 1 -> PENDING[1] stays 1. A write with write_strobe=4'b0011 to ENABLE -> ENABLE unchanged, write_response still 1 a cycle later.
- Masking in ASSERT: while irq=1, write ENABLE=0 -> irq=0 next cycle, STATUS state reads IDLE, and irq_response pulsed afterwards is ignored.
- Reset: assert reset low while in WAIT_CLAIM with PENDING=0xFFFF -> irq, PENDING, read_data and the responses are 0 before the next clock edge.

Source files
------------

// File: rtl/irq_controller_pkg.sv
// irq_controller_pkg: register indices, FSM encoding and claim-width helper
package irq_controller_pkg;

    localparam logic [2:0] REG_ENABLE  = 3'd0;
    localparam logic [2:0] REG_PENDING = 3'd1;
    localparam logic [2:0] REG_TRIGGER = 3'd2;
    localparam logic [2:0] REG_CLAIM   = 3'd3;
    localparam logic [2:0] REG_STATUS  = 3'd4;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        ASSERT     = 2'd1,
        WAIT_CLAIM = 2'd2
    } irq_state_e;

    function automatic int claim_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/irq_controller_gateway.sv
// irq_gateway: per-source previous sample, edge detect and pending set/clear arbitration
module irq_gateway (
    input  logic clock,
    input  logic reset,
    input  logic i_source,
    input  logic i_trigger,
    input  logic i_w1c,
    input  logic i_claim_clear,
    output logic o_pending
);

    logic r_prev;
    logic r_pending;
    logic w_rise;

    assign w_rise    = i_source & ~r_prev;
    assign o_pending = r_pending;

    // level sources follow the line; edge sources latch rises, and a rise beats a clear
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_prev    <= 1'b0;
            r_pending <= 1'b0;
        end else begin
            r_prev    <= i_source;
            r_pending <= !i_trigger ? i_source :
                         w_rise ? 1'b1 :
                         (i_w1c | i_claim_clear) ? 1'b0 : r_pending;
        end
    end

endmodule

// File: rtl/irq_controller.sv
// irq_controller: memory-mapped interrupt aggregator with claim register and irq handshake
module irq_controller
    import irq_controller_pkg::*;
#(
    parameter int NUM_SOURCES = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [31:0]            rw_address,
    output logic [31:0]            read_data,
    input  logic                   read_request,
    output logic                   read_response,
    input  logic [31:0]            write_data,
    input  logic [3:0]             write_strobe,
    input  logic                   write_request,
    output logic                   write_response,
    input  logic [NUM_SOURCES-1:0] irq_sources,
    output logic                   irq,
    input  logic                   irq_response
);

    localparam int CW = claim_width(NUM_SOURCES);

    logic [NUM_SOURCES-1:0] r_enable;
    logic [NUM_SOURCES-1:0] r_trigger;
    logic [NUM_SOURCES-1:0] w_pending;
    logic [NUM_SOURCES-1:0] w_active;
    logic [NUM_SOURCES-1:0] w_w1c;
    logic [NUM_SOURCES-1:0] w_claim_clr;
    logic [CW-1:0]          w_claim_id;
    logic [31:0]            w_rdata;
    logic [31:0]            r_read_data;
    logic                   r_read_response;
    logic                   r_write_response;
    logic [2:0]             w_idx;
    logic                   w_aligned;
    logic                   w_wr;
    logic                   w_rd;
    logic                   w_claim_rd;
    logic                   w_any_active;
    logic                   w_unused;
    irq_state_e             r_state;
    irq_state_e             w_next_state;

    assign w_idx          = rw_address[4:2];
    assign w_aligned      = rw_address[1:0] == 2'b00;
    assign w_wr           = write_request & w_aligned & (write_strobe == 4'hF);
    assign w_rd           = read_request & w_aligned;
    assign w_claim_rd     = w_rd & (w_idx == REG_CLAIM);
    assign w_active       = w_pending & r_enable;
    assign w_any_active   = |w_active;
    assign read_data      = r_read_data;
    assign read_response  = r_read_response;
    assign write_response = r_write_response;
    assign w_unused       = ^{rw_address[31:5], write_data};

    for (genvar g = 0; g < NUM_SOURCES; g++) begin : g_src
        assign w_w1c[g]       = w_wr & (w_idx == REG_PENDING) & write_data[g];
        assign w_claim_clr[g] = w_claim_rd & (w_claim_id == CW'(g + 1));
        irq_gateway u_gateway (
            .clock         (clock),
            .reset         (reset),
            .i_source      (irq_sources[g]),
            .i_trigger     (r_trigger[g]),
            .i_w1c         (w_w1c[g]),
            .i_claim_clear (w_claim_clr[g]),
            .o_pending     (w_pending[g])
        );
    end

    // lowest-index active source wins; scanning downward leaves the lowest one last
    always_comb begin
        w_claim_id = '0;
        for (int i = NUM_SOURCES - 1; i >= 0; i--)
            w_claim_id = w_active[i] ? CW'(i + 1) : w_claim_id;
    end

    // register read mux; unmapped indices read as zero
    always_comb begin
        w_rdata = (w_idx == REG_ENABLE)  ? 32'(r_enable)  :
                  (w_idx == REG_PENDING) ? 32'(w_pending) :
                  (w_idx == REG_TRIGGER) ? 32'(r_trigger) :
                  (w_idx == REG_CLAIM)   ? 32'(w_claim_id) :
                  (w_idx == REG_STATUS)  ? {29'd0, r_state, w_any_active} : 32'd0;
    end

    // configuration registers accept only full-word aligned writes
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_enable  <= '0;
            r_trigger <= '0;
        end else begin
            if (w_wr && w_idx == REG_ENABLE)  r_enable  <= write_data[NUM_SOURCES-1:0];
            if (w_wr && w_idx == REG_TRIGGER) r_trigger <= write_data[NUM_SOURCES-1:0];
        end
    end

    // bus responses echo the requests one cycle later; read data holds unless an aligned read
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_read_data      <= '0;
            r_read_response  <= 1'b0;
            r_write_response <= 1'b0;
        end else begin
            r_read_response  <= read_request;
            r_write_response <= write_request;
            if (w_rd) r_read_data <= w_rdata;
        end
    end

    // irq handshake state register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_next_state;
    end

    // irq handshake transitions; acknowledge takes precedence over a same-cycle drop
    always_comb begin
        w_next_state = IDLE;
        case (r_state)
            IDLE:       w_next_state = w_any_active ? ASSERT : IDLE;
            ASSERT:     w_next_state = irq_response ? WAIT_CLAIM : (w_any_active ? ASSERT : IDLE);
            WAIT_CLAIM: w_next_state = (w_claim_rd || !w_any_active) ? IDLE : WAIT_CLAIM;
            default:    w_next_state = IDLE;
        endcase
    end

    // irq is high exactly while the handshake is in ASSERT
    always_comb begin
        irq = (r_state == ASSERT);
    end

endmodule

// File: tb/tb_irq_controller.sv
// tb_irq_controller: table vectors, directed corner sequences and random model checking
module tb_irq_controller;

    localparam int NS = 16;

    logic          clock;
    logic          reset;
    logic [31:0]   rw_address;
    logic [31:0]   read_data;
    logic          read_request;
    logic          read_response;
    logic [31:0]   write_data;
    logic [3:0]    write_strobe;
    logic          write_request;
    logic          write_response;
    logic [NS-1:0] irq_sources;
    logic          irq;
    logic          irq_response;

    int vectors = 0;
    int miscompares = 0;

    irq_controller #(.NUM_SOURCES(NS)) dut (
        .clock          (clock),
        .reset          (reset),
        .rw_address     (rw_address),
        .read_data      (read_data),
        .read_request   (read_request),
        .read_response  (read_response),
        .write_data     (write_data),
        .write_strobe   (write_strobe),
        .write_request  (write_request),
        .write_response (write_response),
        .irq_sources    (irq_sources),
        .irq            (irq),
        .irq_response   (irq_response)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        bit          is_wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl[16];

    logic [15:0] m_en, m_trig, m_pend, m_prev;
    int          m_st;
    logic [31:0] m_rd;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
        rw_address = addr;
        write_data = data;
        write_strobe = strb;
        write_request = 1'b1;
        tick();
        write_request = 1'b0;
        check("write_response", {31'd0, write_response}, 32'd1);
    endtask

    task automatic rd(input string name, input logic [31:0] addr, input logic [31:0] exp);
        rw_address = addr;
        read_request = 1'b1;
        tick();
        read_request = 1'b0;
        check({name, "_resp"}, {31'd0, read_response}, 32'd1);
        check(name, read_data, exp);
    endtask

    task automatic do_reset();
        read_request = 1'b0;
        write_request = 1'b0;
        irq_response = 1'b0;
        irq_sources = '0;
        rw_address = '0;
        write_data = '0;
        write_strobe = 4'h0;
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    // spec-level model advanced once per clock edge from the inputs about to be sampled
    task automatic model_step();
        logic [15:0] act;
        logic [15:0] nxt;
        logic [31:0] rv;
        logic [2:0]  idx;
        int          cid;
        bit          any, aligned, wok, claim, rd_claim;
        act = m_pend & m_en;
        any = act != 0;
        cid = 0;
        for (int i = 0; i < NS; i++) if (act[i] && cid == 0) cid = i + 1;
        idx = rw_address[4:2];
        aligned = rw_address[1:0] == 2'b00;
        case (idx)
            3'd0: rv = {16'd0, m_en};
            3'd1: rv = {16'd0, m_pend};
            3'd2: rv = {16'd0, m_trig};
            3'd3: rv = cid;
            3'd4: rv = m_st * 2 + (any ? 1 : 0);
            default: rv = 0;
        endcase
        if (read_request && aligned) m_rd = rv;
        wok = write_request && aligned && write_strobe == 4'hF;
        rd_claim = read_request && aligned && idx == 3'd3;
        for (int i = 0; i < NS; i++) begin
            claim = rd_claim && cid == i + 1;
            if (!m_trig[i]) nxt[i] = irq_sources[i];
            else if (irq_sources[i] && !m_prev[i]) nxt[i] = 1'b1;
            else if ((wok && idx == 3'd1 && write_data[i]) || claim) nxt[i] = 1'b0;
            else nxt[i] = m_pend[i];
        end
        if (m_st == 0) m_st = any ? 1 : 0;
        else if (m_st == 1) m_st = irq_response ? 2 : (any ? 1 : 0);
        else m_st = (rd_claim || !any) ? 0 : 2;
        if (wok && idx == 3'd0) m_en = write_data[15:0];
        if (wok && idx == 3'd2) m_trig = write_data[15:0];
        m_pend = nxt;
        m_prev = irq_sources;
    endtask

    initial begin
        do_reset();
        check("reset_irq", {31'd0, irq}, 32'd0);
        check("reset_read_data", read_data, 32'd0);
        check("reset_rresp", {31'd0, read_response}, 32'd0);

        tbl[0]  = '{1, 32'h00, 32'hFFFF_FFFF, 4'hF, 32'h0};
        tbl[1]  = '{0, 32'h00, 32'h0, 4'h0, 32'h0000_FFFF};
        tbl[2]  = '{1, 32'h00, 32'h1234_5678, 4'h3, 32'h0};
        tbl[3]  = '{0, 32'h00, 32'h0, 4'h0, 32'h0000_FFFF};
        tbl[4]  = '{1, 32'h08, 32'hFFFF_A5A5, 4'hF, 32'h0};
        tbl[5]  = '{0, 32'h08, 32'h0, 4'h0, 32'h0000_A5A5};
        tbl[6]  = '{1, 32'h00, 32'h0000_0F0F, 4'hF, 32'h0};
        tbl[7]  = '{0, 32'h00, 32'h0, 4'h0, 32'h0000_0F0F};
        tbl[8]  = '{0, 32'h09, 32'h0, 4'h0, 32'h0000_0F0F};
        tbl[9]  = '{0, 32'h14, 32'h0, 4'h0, 32'h0};
        tbl[10] = '{1, 32'h14, 32'hFFFF_FFFF, 4'hF, 32'h0};
        tbl[11] = '{0, 32'h1C, 32'h0, 4'h0, 32'h0};
        tbl[12] = '{1, 32'h02, 32'h0, 4'hF, 32'h0};
        tbl[13] = '{0, 32'h00, 32'h0, 4'h0, 32'h0000_0F0F};
        tbl[14] = '{0, 32'h0C, 32'h0, 4'h0, 32'h0};
        tbl[15] = '{0, 32'h10, 32'h0, 4'h0, 32'h0};
        for (int i = 0; i < 16; i++) begin
            if (tbl[i].is_wr) wr(tbl[i].addr, tbl[i].data, tbl[i].strb);
            else rd($sformatf("table%0d", i), tbl[i].addr, tbl[i].exp);
        end

        // level source through the full handshake
        do_reset();
        wr(32'h00, 32'h1, 4'hF);
        irq_sources = 16'h0001;
        tick();
        check("level_irq_early", {31'd0, irq}, 32'd0);
        tick();
        check("level_irq_rise", {31'd0, irq}, 32'd1);
        rd("level_pending", 32'h04, 32'h1);
        irq_response = 1'b1;
        tick();
        irq_response = 1'b0;
        check("level_irq_ack", {31'd0, irq}, 32'd0);
        rd("level_status_wait", 32'h10, 32'h5);
        rd("level_claim", 32'h0C, 32'h1);
        irq_sources = 16'h0;
        tick();
        rd("level_pending_drop", 32'h04, 32'h0);
        tick();
        check("level_irq_idle", {31'd0, irq}, 32'd0);

        // edge source persists after the pulse and is cleared by claim
        do_reset();
        wr(32'h08, 32'h4, 4'hF);
        wr(32'h00, 32'h4, 4'hF);
        irq_sources = 16'h0004;
        tick();
        irq_sources = 16'h0;
        tick();
        tick();
        rd("edge_pending", 32'h04, 32'h4);
        rd("edge_claim", 32'h0C, 32'h3);
        rd("edge_pending_clr", 32'h04, 32'h0);
        rd("edge_claim_none", 32'h0C, 32'h0);

        // priority between two edge sources
        do_reset();
        wr(32'h08, 32'h28, 4'hF);
        wr(32'h00, 32'h28, 4'hF);
        irq_sources = 16'h0028;
        tick();
        irq_sources = 16'h0;
        tick();
        rd("prio_claim1", 32'h0C, 32'h4);
        rd("prio_claim2", 32'h0C, 32'h6);
        rd("prio_claim3", 32'h0C, 32'h0);

        // set beats a same-edge W1C; partial writes are dropped
        do_reset();
        wr(32'h08, 32'h2, 4'hF);
        wr(32'h00, 32'h2, 4'hF);
        irq_sources = 16'h0002;
        tick();
        irq_sources = 16'h0;
        tick();
        irq_sources = 16'h0002;
        wr(32'h04, 32'h2, 4'hF);
        rd("w1c_race_pending", 32'h04, 32'h2);
        irq_sources = 16'h0;
        tick();
        wr(32'h04, 32'h2, 4'hF);
        rd("w1c_clear_pending", 32'h04, 32'h0);
        wr(32'h00, 32'hFFFF, 4'h3);
        rd("partial_enable", 32'h00, 32'h2);

        // masking while asserted returns to IDLE and ignores a late acknowledge
        do_reset();
        wr(32'h00, 32'h1, 4'hF);
        irq_sources = 16'h0001;
        tick();
        tick();
        check("mask_irq_on", {31'd0, irq}, 32'd1);
        wr(32'h00, 32'h0, 4'hF);
        tick();
        check("mask_irq_off", {31'd0, irq}, 32'd0);
        rd("mask_status", 32'h10, 32'h0);
        irq_response = 1'b1;
        tick();
        irq_response = 1'b0;
        check("mask_ack_ignored", {31'd0, irq}, 32'd0);
        rd("mask_status2", 32'h10, 32'h0);
        irq_sources = 16'h0;

        // asynchronous reset from WAIT_CLAIM
        do_reset();
        wr(32'h00, 32'hFFFF, 4'hF);
        irq_sources = 16'hFFFF;
        tick();
        tick();
        check("rst_irq_on", {31'd0, irq}, 32'd1);
        irq_response = 1'b1;
        tick();
        irq_response = 1'b0;
        rd("rst_status", 32'h10, 32'h5);
        rd("rst_pending", 32'h04, 32'hFFFF);
        #2;
        reset = 1'b0;
        #1;
        check("rst_async_irq", {31'd0, irq}, 32'd0);
        check("rst_async_rdata", read_data, 32'd0);
        check("rst_async_rresp", {31'd0, read_response}, 32'd0);
        check("rst_async_wresp", {31'd0, write_response}, 32'd0);
        irq_sources = 16'h0;
        tick();
        reset = 1'b1;
        rd("rst_pending_after", 32'h04, 32'h0);
        rd("rst_status_after", 32'h10, 32'h0);

        // random traffic against the model
        do_reset();
        m_en = '0; m_trig = '0; m_pend = '0; m_prev = '0; m_st = 0; m_rd = '0;
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 2) == 0) irq_sources = 16'($urandom);
            irq_response = $urandom_range(0, 3) == 0;
            write_request = $urandom_range(0, 4) == 0;
            read_request = $urandom_range(0, 2) == 0;
            rw_address = (32'($urandom_range(0, 2) == 0 ? 3 : $urandom_range(0, 7)) << 2)
                         | (($urandom_range(0, 9) == 0) ? 32'd1 : 32'd0);
            write_data = $urandom;
            write_strobe = ($urandom_range(0, 4) == 0) ? 4'($urandom) : 4'hF;
            model_step();
            tick();
            check("rnd_irq", {31'd0, irq}, {31'd0, m_st == 1});
            check("rnd_rresp", {31'd0, read_response}, {31'd0, read_request});
            check("rnd_wresp", {31'd0, write_response}, {31'd0, write_request});
            check("rnd_rdata", read_data, m_rd);
        end
        read_request = 1'b0;
        write_request = 1'b0;
        irq_response = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
